vmem_arbiter: RTL and testbench

//  Shares the single-port frame memory (24-bit RGB, 2^19 words, address {h_addr[9:0], v_addr[8:0]}) between two users:
//  - the VGA scan-out read path, which has absolute priority while the display is active;
//  - one writer client (keyboard/UART-driven drawing) using a valid/ready handshake.

---
 rtl/vmem_arb_pkg.sv | 20 ++
 rtl/vmem_wr_fifo.sv | 71 +++++++
 rtl/vmem_arbiter.sv | 137 +++++++++++++
 tb/tb_vmem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_arb_pkg.sv
// Shared types and default widths for the frame-memory arbiter and its write buffer.
package vmem_arb_pkg;

    localparam int unsigned ADDR_W             = 19;
    localparam int unsigned DATA_W             = 24;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
    localparam int unsigned STAT_W             = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DISP  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/vmem_wr_fifo.sv
// Synchronous write buffer of wr_entry_t; push is ignored when full, pop when empty.
module vmem_wr_fifo
    import vmem_arb_pkg::*;
#(
    parameter  int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  wr_entry_t        din,
    input  logic             pop,
    output wr_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wr_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/vmem_arbiter.sv
// Frame-memory arbiter: scan-out reads own memory during active video, buffered writes drain in blanking.
// Optional statistics outputs (stall_cnt, wr_cnt) are built when VMEM_ARB_STATS_EN is defined.
module vmem_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              vga_valid,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef VMEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] wr_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e           state_q, state_d;
    wr_entry_t        push_entry;
    wr_entry_t        head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             last_pop;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        push_entry.addr = wr_addr;
        push_entry.data = wr_data;
    end

    vmem_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (push_entry),
        .pop    (pop),
        .dout   (head),
        .full   (full),
        .empty  (empty),
        .count  (fifo_count)
    );

    assign wr_ready = !full;
    assign push     = wr_valid && !full;
    assign busy     = !empty;

    // Live vga_valid gates the write so it can never collide with a display read.
    assign mem_we   = (state_q == DRAIN) && !vga_valid && !empty;
    assign pop      = mem_we;
    assign last_pop = pop && !push && (fifo_count == CNT_W'(1));

    assign mem_addr  = vga_valid ? vga_addr : head.addr;
    assign vga_data  = vga_valid ? mem_rdata : '0;
    assign mem_wdata = head.data;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (vga_valid) begin
                    state_d = DISP;
                end else if (!empty) begin
                    state_d = DRAIN;
                end
            end
            DISP: begin
                if (!vga_valid) begin
                    state_d = empty ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (vga_valid) begin
                    state_d = DISP;
                end else if (empty || last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef VMEM_ARB_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] wr_cnt_q, wr_cnt_d;

    // Stall counter saturates; write counter wraps.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        if (wr_valid && !wr_ready && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
        if (mem_we) begin
            wr_cnt_d = wr_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
            wr_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign wr_cnt    = wr_cnt_q;
`endif

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: directed scenarios plus a randomized phase against a queue-based model.
module tb_vmem_arbiter;
    import vmem_arb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              vga_valid;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
`ifdef VMEM_ARB_STATS_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       wr_cnt;
`endif

    vmem_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .vga_valid (vga_valid),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
`ifdef VMEM_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .wr_cnt    (wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Frame memory behaviour: combinational read, write on the clock.
    bit [DATA_W-1:0] vmem    [0:524287];
    bit [DATA_W-1:0] exp_mem [0:524287];
    assign mem_rdata = vmem[mem_addr];
    always @(posedge clk) if (mem_we) vmem[mem_addr] <= mem_wdata;

    wr_entry_t model_q[$];
    int  n_pass = 0;
    int  n_tot = 0;
    int  n_writes = 0;
    int  pushes_rst = 0;
    int  writes_rst = 0;
    int  exp_stall = 0;
    int  idle_run = 0;
    bit  xfer = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // Model: entries leave in arrival order, one per write, capacity DEPTH.
    always @(negedge clk) begin
        int pre;
        wr_entry_t e;
        if (!resetn) begin
            model_q.delete();
            pushes_rst = 0;
            writes_rst = 0;
            exp_stall  = 0;
            idle_run   = 0;
        end else begin
            pre = model_q.size();
            check("wr_ready", wr_ready, 32'(pre < DEPTH));
            check("busy", busy, 32'(pre != 0));
            check("vga_data", vga_data, vga_valid ? 32'(vmem[vga_addr]) : 32'd0);
            if (vga_valid) check("mem_addr_vga", mem_addr, vga_addr);
            else if (pre != 0) check("mem_addr_head", mem_addr, model_q[0].addr);
            if (pre != 0) check("mem_wdata_head", mem_wdata, model_q[0].data);
            if (!vga_valid && !mem_we && pre != 0) idle_run++;
            else idle_run = 0;
            check("drain_rate", 32'(idle_run <= 1), 32'd1);
            if (mem_we) begin
                check("we_vs_active", vga_valid, 32'd0);
                check("we_nonempty", 32'(pre != 0), 32'd1);
                if (pre != 0) begin
                    e = model_q.pop_front();
                    exp_mem[e.addr] = e.data;
                end
                n_writes++;
                writes_rst++;
            end
            if (wr_valid && pre < DEPTH) begin
                e.addr = wr_addr;
                e.data = wr_data;
                model_q.push_back(e);
                pushes_rst++;
            end
            if (wr_valid && pre >= DEPTH) exp_stall++;
        end
    end

    task automatic cycle();
        @(negedge clk);
        xfer = wr_valid && wr_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic push_wait(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int budget);
        bit ok = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (xfer) begin
                ok = 1'b1;
                break;
            end
        end
        wr_valid = 1'b0;
        check("push_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) cycle();
        check("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        resetn = 1'b0; vga_valid = 1'b0; vga_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_we", mem_we, 32'd0);
        check("rst_wr_ready", wr_ready, 32'd1);
        check("rst_busy", busy, 32'd0);
        check("rst_vga_data", vga_data, 32'd0);
`ifdef VMEM_ARB_STATS_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_wr_cnt", wr_cnt, 32'd0);
`endif
        resetn = 1'b1;
        cycle();

        // Write during active video waits for blanking.
        vga_valid = 1'b1;
        vga_addr  = 19'h12345;
        push_wait(19'h00123, 24'hFF0000, 4);
        w0 = n_writes;
        repeat (4) begin
            cycle();
            check("t2_we_active", mem_we, 32'd0);
        end
        check("t2_busy_held", busy, 32'd1);
        vga_valid = 1'b0;
        repeat (4) cycle();
        check("t2_write_count", 32'(n_writes - w0), 32'd1);
        check("t2_mem_value", vmem[19'h00123], 32'hFF0000);
        check("t2_busy_after", busy, 32'd0);

        // Back-pressure: four accepted, fifth held until blanking frees a slot.
        vga_valid = 1'b1;
        w0 = n_writes;
        wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_addr = 19'(32'h200 + k);
            wr_data = 24'($urandom);
            cycle();
            check("t3_accept", 32'(xfer), 32'd1);
        end
        wr_addr = 19'h204;
        wr_data = 24'hABCDEF;
        repeat (6) begin
            cycle();
            check("t3_held", 32'(xfer), 32'd0);
            check("t3_ready_low", wr_ready, 32'd0);
        end
        vga_valid = 1'b0;
        begin
            bit ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                cycle();
                if (xfer) begin ok = 1'b1; break; end
            end
            check("t3_fifth_accepted", 32'(ok), 32'd1);
        end
        wr_valid = 1'b0;
        wait_idle(20);
        check("t3_write_count", 32'(n_writes - w0), 32'd5);
        check("t3_fifth_value", vmem[19'h204], 32'hABCDEF);

        // Blanking ends after one write; the rest waits for the next blanking.
        vga_valid = 1'b1;
        for (int k = 0; k < 3; k++) push_wait(19'(32'h300 + k), 24'($urandom), 4);
        w0 = n_writes;
        vga_valid = 1'b0;
        for (int i = 0; i < 6 && n_writes == w0; i++) cycle();
        check("t4_first_write", 32'(n_writes - w0), 32'd1);
        vga_valid = 1'b1;
        vga_addr  = 19'h54321;
        #1;
        check("t4_we_drop", mem_we, 32'd0);
        check("t4_addr_switch", mem_addr, 32'h54321);
        check("t4_busy", busy, 32'd1);
        repeat (5) cycle();
        check("t4_no_write_active", 32'(n_writes - w0), 32'd1);
        vga_valid = 1'b0;
        wait_idle(20);
        check("t4_total", 32'(n_writes - w0), 32'd3);

        // Same address twice: later write wins.
        push_wait(19'h00010, 24'h111111, 4);
        push_wait(19'h00010, 24'h222222, 4);
        wait_idle(20);
        vga_valid = 1'b1;
        vga_addr  = 19'h00010;
        #1;
        check("t5_readback", vga_data, 32'h222222);
        check("t5_model", exp_mem[19'h00010], 32'h222222);
        cycle();
        vga_valid = 1'b0;

        // Reset in the middle of a drain discards buffered entries.
        vga_valid = 1'b1;
        for (int k = 0; k < 3; k++) push_wait(19'(32'h400 + k), 24'($urandom), 4);
        w0 = n_writes;
        vga_valid = 1'b0;
        for (int i = 0; i < 6 && n_writes == w0; i++) cycle();
        resetn = 1'b0;
        #1;
        check("rst_mid_we", mem_we, 32'd0);
        check("rst_mid_busy", busy, 32'd0);
        check("rst_mid_ready", wr_ready, 32'd1);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cycle();

        // Hold a request against a full buffer for ten cycles.
        vga_valid = 1'b1;
        wr_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wr_addr = 19'(32'h500 + k);
            wr_data = 24'($urandom);
            cycle();
            check("t6_accept", 32'(xfer), 32'd1);
        end
        wr_addr = 19'h504;
        wr_data = 24'h5A5A5A;
        repeat (10) cycle();
        wr_valid = 1'b0;
        check("t6_model_stall", 32'(exp_stall), 32'd10);
`ifdef VMEM_ARB_STATS_EN
        check("t6_stall_cnt", stall_cnt, 32'd10);
`endif
        vga_valid = 1'b0;
        wait_idle(20);
`ifdef VMEM_ARB_STATS_EN
        check("t6_wr_cnt", wr_cnt, 32'd4);
`endif

        // Randomized traffic with random active/blanking runs.
        xfer = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(15) == 0) vga_valid = ~vga_valid;
            vga_addr = 19'($urandom_range(63));
            if (!wr_valid || xfer) begin
                wr_valid = 1'($urandom_range(1));
                wr_addr  = 19'($urandom_range(63));
                wr_data  = 24'($urandom);
            end
            cycle();
        end
        wr_valid  = 1'b0;
        vga_valid = 1'b0;
        wait_idle(40);
        check("rand_all_written", 32'(writes_rst), 32'(pushes_rst));
`ifdef VMEM_ARB_STATS_EN
        check("rand_stall_cnt", stall_cnt, 32'(exp_stall));
        check("rand_wr_cnt", wr_cnt, 32'(writes_rst));
`endif
        for (int a = 0; a < 64; a++) begin
            check("rand_mem_image", vmem[a], exp_mem[a]);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
